// File: rtl/addr_mem_ctrl.sv
// Command front-end and storage for a small single-port register memory.
// Writes complete in one edge; reads return registered data one edge after the command.
module addr_mem_ctrl #(
    parameter int AW    = 6,
    parameter int DW    = 8,
    parameter int DEPTH = 48
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          wr,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ready,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          err,
    output logic [15:0]   wr_cnt,
    output logic [15:0]   rd_cnt,
    output logic [7:0]    drop_cnt
);

    typedef enum logic {IDLE, RD} state_e;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic          ready_q, ready_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          in_range;
    logic          mem_we;

    // Storage is deliberately left out of reset so contents survive it.
    logic [DW-1:0] mem [DEPTH];

    assign in_range = {1'b0, addr} < DEPTH_W;

    always_comb begin
        state_d    = state_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        drop_cnt_d = drop_cnt_q;
        raddr_d    = raddr_q;
        mem_we     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (wr) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end else begin
                        raddr_d = addr;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                rdata_d  = mem[raddr_q];
                rvalid_d = 1'b1;
                rd_cnt_d = rd_cnt_q + 16'd1;
                state_d  = IDLE;
                if (en && drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            drop_cnt_q <= '0;
            raddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            raddr_q    <= raddr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= wdata;
        end
    end

    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;
    assign wr_cnt   = wr_cnt_q;
    assign rd_cnt   = rd_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_addr_mem_ctrl.sv
// Directed plus randomized bench for addr_mem_ctrl against a command-level reference model.
module tb_addr_mem_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 48;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          err;
    logic [15:0]   wr_cnt;
    logic [15:0]   rd_cnt;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents, written flags, pending read, expected outputs.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_written [DEPTH];
    bit            m_pend;
    int            m_paddr;
    logic [DW-1:0] m_rdata;
    bit            m_rvalid, m_err;
    int            m_wr, m_rd, m_drop;

    addr_mem_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .wdata(wdata),
        .ready(ready), .rdata(rdata), .rvalid(rvalid), .err(err),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend   = 0;
        m_paddr  = 0;
        m_rdata  = '0;
        m_rvalid = 0;
        m_err    = 0;
        m_wr     = 0;
        m_rd     = 0;
        m_drop   = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ready"},    32'(ready),    32'(!m_pend));
        chk({tag, ".rvalid"},   32'(rvalid),   32'(m_rvalid));
        chk({tag, ".err"},      32'(err),      32'(m_err));
        chk({tag, ".rdata"},    32'(rdata),    32'(m_rdata));
        chk({tag, ".wr_cnt"},   32'(wr_cnt),   32'(m_wr & 16'hFFFF));
        chk({tag, ".rd_cnt"},   32'(rd_cnt),   32'(m_rd & 16'hFFFF));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock edge with the given command presented; model advances, then outputs are compared.
    task automatic step(input string tag, input bit e, input bit w, input int a, input int d);
        @(negedge clk);
        en    = e;
        wr    = w;
        addr  = AW'(a);
        wdata = DW'(d);
        @(posedge clk);
        m_rvalid = 0;
        m_err    = 0;
        if (m_pend) begin
            m_rdata  = m_mem[m_paddr];
            m_rvalid = 1;
            m_rd++;
            m_pend   = 0;
            if (e && m_drop < 255) m_drop++;
        end else if (e) begin
            if (a >= DEPTH) begin
                m_err = 1;
            end else if (w) begin
                m_mem[a]     = DW'(d);
                m_written[a] = 1;
                m_wr++;
            end else begin
                m_pend  = 1;
                m_paddr = a;
            end
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1; en = 0; wr = 0; addr = '0; wdata = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_written[i] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) step("idle", 0, 0, 0, 0);

        step("wr12", 1, 1, 12, 8'hA5);
        step("wr14", 1, 1, 14, 8'h3C);
        chk("plan.wr_cnt2", 32'(wr_cnt), 32'd2);
        step("rd12", 1, 0, 12, 0);
        chk("plan.rd_busy", 32'(ready), 32'd0);
        step("rd12.ret", 0, 0, 0, 0);
        chk("plan.rdata_a5", 32'(rdata), 32'hA5);
        chk("plan.rd_cnt1", 32'(rd_cnt), 32'd1);

        step("rd14.a", 1, 0, 14, 0);
        step("rd14.held", 1, 0, 14, 0);
        chk("plan.drop1", 32'(drop_cnt), 32'd1);
        chk("plan.rdata_3c", 32'(rdata), 32'h3C);
        step("rd14.after", 0, 0, 0, 0);
        chk("plan.rvalid_single", 32'(rvalid), 32'd0);

        step("wr56", 1, 1, 56, 8'h77);
        chk("plan.err56", 32'(err), 32'd1);
        step("rd56", 1, 0, 56, 0);
        chk("plan.err56rd", 32'(err), 32'd1);
        step("rd56.after", 0, 0, 0, 0);

        step("wr47", 1, 1, 47, 8'hFF);
        step("rd47", 1, 0, 47, 0);
        step("rd47.ret", 0, 0, 0, 0);
        chk("plan.rdata_ff", 32'(rdata), 32'hFF);
        step("wr48", 1, 1, 48, 8'h11);
        chk("plan.err48", 32'(err), 32'd1);

        step("raw.wr", 1, 1, 5, 8'h5A);
        step("raw.rd", 1, 0, 5, 0);
        step("raw.ret", 0, 0, 0, 0);
        chk("plan.raw", 32'(rdata), 32'h5A);

        step("rd23", 1, 0, 23, 0);
        @(negedge clk);
        en = 0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk_all("rst_mid_rd");
        @(posedge clk);
        #1 chk_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 0, 0, 0, 0);
        step("post_rst.rd12", 1, 0, 12, 0);
        step("post_rst.ret", 0, 0, 0, 0);
        chk("plan.mem_kept", 32'(rdata), 32'hA5);

        // Randomized traffic; reads target only addresses with known contents.
        for (int n = 0; n < 400; n++) begin
            bit e, w;
            int a, d;
            e = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            a = (($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH, 63) : $urandom_range(0, DEPTH - 1));
            d = $urandom_range(0, 255);
            if (e && !w && a < DEPTH && !m_written[a]) w = 1;
            step("rand", e, w, a, d);
        end

        // Drive drop_cnt into saturation with a held read stream.
        for (int n = 0; n < 560; n++) step("sat", 1, 0, 12, 0);
        chk("plan.drop_sat", 32'(drop_cnt), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
